// File: rtl/d5m_pattern_tx.sv
// Terasic D5M-style camera stream generator: FVAL/LVAL framing plus a selectable
// 12-bit raw Bayer test pattern, all outputs registered.
module d5m_pattern_tx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 32,
  parameter int F2L      = 4,
  parameter int V_BLANK  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_mode,
  output logic        o_fval,
  output logic        o_lval,
  output logic [11:0] o_data,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  if (H_ACTIVE < 1 || H_ACTIVE > 4095 || V_ACTIVE < 1 || V_ACTIVE > 4095 ||
      H_BLANK < 1 || H_BLANK > 4095 || F2L < 1 || F2L > 4095 ||
      V_BLANK < 1 || V_BLANK > 4095) begin : g_param_err
    $error("d5m_pattern_tx: every timing parameter must lie in 1..4095");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_VBLANK = 3'd4;

  localparam logic [11:0] H_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HB_LAST = 12'(H_BLANK - 1);
  localparam logic [11:0] F2L_LAST = 12'(F2L - 1);
  localparam logic [11:0] VB_LAST = 12'(V_BLANK - 1);

  logic [2:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [1:0]  mode_q, mode_d;
  logic        stop_q, stop_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        fval_q, fval_d;
  logic        lval_q, lval_d;
  logic        busy_q, busy_d;
  logic [11:0] data_q, data_d;

  // cnt_q times SETUP/HBLANK/VBLANK; x_q is the pixel index inside ACTIVE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    stop_d      = stop_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q != S_IDLE && i_stop) begin
      stop_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_d = S_SETUP;
          cnt_d   = 12'd0;
          y_d     = 12'd0;
          mode_d  = i_mode;
        end
      end
      S_SETUP: begin
        if (cnt_q == F2L_LAST) begin
          state_d = S_ACTIVE;
          x_d     = 12'd0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_ACTIVE: begin
        if (x_q == H_LAST) begin
          cnt_d = 12'd0;
          if (y_q == V_LAST) begin
            state_d     = S_VBLANK;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            state_d = S_HBLANK;
            y_d     = y_q + 12'd1;
          end
        end else begin
          x_d = x_q + 12'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = S_ACTIVE;
          x_d     = 12'd0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          if (stop_q || i_stop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETUP;
            cnt_d   = 12'd0;
            y_d     = 12'd0;
            mode_d  = i_mode;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      stop_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    fval_d = (state_d == S_SETUP) || (state_d == S_ACTIVE) || (state_d == S_HBLANK);
    lval_d = (state_d == S_ACTIVE);
    busy_d = (state_d != S_IDLE);
    data_d = 12'h000;
    if (lval_d) begin
      case (mode_d)
        2'd0: data_d = {x_d[9:0], 2'b00};
        2'd1: data_d = {y_d[9:0], 2'b00};
        2'd2: begin
          if (x_d[0] == y_d[0]) begin
            data_d = 12'h800;
          end else if (!y_d[0]) begin
            data_d = 12'hFFF;
          end else begin
            data_d = 12'h000;
          end
        end
        default: data_d = {frame_cnt_q[3:0], x_d[7:0]};
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 12'd0;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      mode_q      <= 2'd0;
      stop_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= 12'h000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      stop_q      <= stop_d;
      frame_cnt_q <= frame_cnt_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
    end
  end

  assign o_fval      = fval_q;
  assign o_lval      = lval_q;
  assign o_data      = data_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/d5m_pattern_tx.md
D5M_PATTERN_TX -- requirements
Module: d5m_pattern_tx

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640: active pixels per line (LVAL high cycles).
REQ-002 SHALL provide parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL provide parameter H_BLANK, default 32: LVAL-low cycles between lines within a frame.
REQ-004 SHALL provide parameter F2L, default 4: cycles FVAL high before the first LVAL of a frame.
REQ-005 SHALL provide parameter V_BLANK, default 64: FVAL-low cycles after each frame.
REQ-006 SHALL accept only parameter values of 1..4095 for all parameters.
REQ-007 SHALL have port i_clk, input, 1: single clock (pixel clock); all logic uses its rising edge.
REQ-008 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port i_start, input, 1: one-cycle pulse that starts streaming.
REQ-010 SHALL have port i_stop, input, 1: one-cycle pulse that requests a stop at the end of the current frame.
REQ-011 SHALL have port i_mode, input, 2: pattern select.
REQ-012 SHALL have port o_fval, output, 1: frame valid, D5M FVAL semantics.
REQ-013 SHALL have port o_lval, output, 1: line valid, D5M LVAL semantics.
REQ-014 SHALL have port o_data, output, 12: raw Bayer pixel data.
REQ-015 SHALL have port o_frame_cnt, output, 16: count of completed frames.
REQ-016 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL register all outputs, with no combinational path from any input to any output.
REQ-018 SHALL implement FSM states IDLE, SETUP, ACTIVE, HBLANK and VBLANK.
- IDLE: fval=0, lval=0.
- SETUP: fval=1, lval=0 for F2L cycles.
- ACTIVE: fval=1, lval=1 for H_ACTIVE cycles.
- HBLANK: fval=1, lval=0 for H_BLANK cycles.
- VBLANK: fval=0, lval=0 for V_BLANK cycles.
REQ-019 SHALL sequence states as IDLE -> SETUP -> ACTIVE, then ACTIVE -> HBLANK -> ACTIVE for lines 0..V_ACTIVE-2, then last ACTIVE -> VBLANK.
REQ-020 SHALL leave VBLANK to IDLE if a stop is pending, otherwise to SETUP.
REQ-021 SHALL, when i_start=1 in IDLE at edge N, drive o_fval=1 from edge N+1 (latency 1).
REQ-022 SHALL ignore i_start while o_busy=1.
REQ-023 SHALL set a stop_pending flag when i_stop=1 while busy, and clear it on entry to IDLE.
REQ-024 SHALL ignore i_start in IDLE when i_stop=1 in the same cycle (stop wins).
REQ-025 SHALL keep pixel counter x (0..H_ACTIVE-1) and line counter y (0..V_ACTIVE-1), 12 bits each.
- x resets to 0 at each ACTIVE entry.
- y resets to 0 at SETUP entry and increments on ACTIVE exit.
REQ-026 SHALL sample i_mode on SETUP entry and hold it constant for the whole frame.
REQ-027 SHALL generate o_data by mode:
- 0: {x[9:0],2'b00}.
- 1: {y[9:0],2'b00}.
- 2: Bayer checker: G=12'h800 where x[0]==y[0]; R=12'hFFF where y even and x odd; B=12'h000 where y odd and x even.
- 3: {o_frame_cnt[3:0],x[7:0]}.
REQ-028 SHALL drive o_data=12'h000 whenever o_lval=0.
REQ-029 SHALL increment o_frame_cnt by 1, modulo 2^16 with 16'hFFFF wrapping to 16'h0000, in the cycle o_fval falls.
REQ-030 SHALL not count a frame that is aborted by reset.
REQ-031 SHALL produce exactly F2L + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK cycles of o_fval=1 per frame.
REQ-032 SHALL produce exactly V_BLANK cycles of fval=0 between back-to-back frames.
REQ-033 SHALL support V_ACTIVE=1 with no HBLANK state in the frame.
REQ-034 SHALL drive o_busy=0 only in IDLE.

Reset
REQ-035 SHALL, while i_rst_n=0, immediately force state=IDLE, o_fval=0, o_lval=0, o_data=0, o_frame_cnt=0, o_busy=0, stop_pending=0, x=0, y=0 and sampled mode=0, regardless of the clock.
REQ-036 SHALL, after reset deassertion, remain in IDLE until an i_start pulse.

Verification (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, F2L=1, V_BLANK=3 unless noted)
REQ-037 SHALL pass this scenario: start pulse, mode=0 -> fval high 11 cycles; lval pattern 0,1111,00,1111; o_data 000,004,008,00C per line; fval falls; frame_cnt=1; SETUP re-entered after 3 low cycles.
REQ-038 SHALL pass this scenario: mode=2 -> line0 data 800,FFF,800,FFF; line1 data 000,800,000,800.
REQ-039 SHALL pass this scenario: stop pulse during line 0 of frame 3 -> frame completes; frame_cnt=3; IDLE after VBLANK; busy=0; later start begins a new frame.
REQ-040 SHALL pass this scenario: start and stop in the same IDLE cycle -> remains IDLE with fval=0; start alone during streaming has no effect.
REQ-041 SHALL pass this scenario: reset asserted mid-ACTIVE -> fval, lval, data and frame_cnt read 0 before the next clock edge; no activity until next start.
REQ-042 SHALL pass this scenario: frame_cnt preloaded via 65535 frames (or forced) -> next frame end wraps frame_cnt to 0; mode changed mid-frame takes effect only on the next frame.
